led_round_controller: RTL and testbench
=======================================

// Module: led_round_controller
// PURPOSE
//  Game sequencer for the LED_Timer block: runs a game of ROUNDS reaction rounds.
//  Each round it reconfigures the timer, waits a pseudo-random gap, then enables the timer.
//  It scores the player's button press against the timer's timeout.
//  Sits between the debounced button/start inputs and LED_Timer; drives Reconfigure/En, reads LED_timeout.
// PARAMETERS
//  ROUNDS    5       rounds per game, 1..15
//  GAP_MIN   50      minimum idle cycles before the timer is enabled
//  GAP_W     8       width of the random gap addend (gap = GAP_MIN + lfsr[GAP_W-1:0])
//  RT_W      16      reaction-time counter width
//  SEED      16'hACE1 LFSR reset value, must be nonzero
// PORTS
//  clk            in   1      system clock
//  rst            in   1      synchronous reset, active-high
//  start          in   1      1-cycle pulse, starts a game from IDLE or DONE
//  abort          in   1      level; returns to IDLE next cycle
//  btn            in   1      debounced 1-cycle press pulse
//  LED_timeout    in   1      timer expired (from LED_Timer)
//  Reconfigure    out  1      1-cycle reload pulse to LED_Timer
//  En             out  1      timer enable, high only in RUN
//  busy           out  1      high in every state except IDLE and DONE
//  done           out  1      high in DONE
//  hit_p          out  1      1-cycle pulse on a scored round
//  miss_p         out  1      1-cycle pulse on a lost round (early press or timeout)
//  round_idx      out  4      current round, 0..ROUNDS-1
//  score          out  4      hits this game
//  last_rt        out  RT_W   cycles from En rise to press in the last hit round
// BEHAVIOUR
//  Reset: state=IDLE. All outputs 0; last_rt=0; LFSR=SEED.
//  LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11. Advances every cycle incl. IDLE, never 0.
//  IDLE: start -> RECONF; score<=0; round_idx<=0.
//  RECONF (1 cycle): Reconfigure=1; gap_cnt<=GAP_MIN+lfsr[GAP_W-1:0]; -> GAP.
//  GAP: gap_cnt decrements each cycle.
//   - btn -> MISS (false start); timer is never enabled.
//   - gap_cnt==0 -> RUN; rt_cnt<=0.
//  RUN: En=1; rt_cnt increments, saturating at all-ones.
//   - btn -> HIT; last_rt<=rt_cnt+1.
//   - LED_timeout (no btn) -> MISS.
//   - btn and LED_timeout in the same cycle -> HIT (press wins).
//  HIT (1 cycle): hit_p=1; score<=score+1; En=0.
//  MISS (1 cycle): miss_p=1; En=0.
//  HIT/MISS exit:
//   - round_idx==ROUNDS-1 -> DONE; round_idx holds.
//   - otherwise round_idx+1 -> RECONF.
//  DONE: done=1; score and last_rt hold; start -> RECONF with score/round cleared.
//  Ignored inputs: btn outside GAP/RUN; LED_timeout outside RUN; start outside IDLE/DONE.
//  abort: highest priority in every state.
//   - Next state IDLE; En and Reconfigure drop the following cycle.
//   - score, round_idx and last_rt hold their values.
//  rst mid-game: identical to the reset state; in-flight hit/miss pulses are lost.
//  Outputs are registered and decoded from state; response latency is 1 cycle after the input.
// STRUCTURE
//  led_game_defs.vh: state encodings (IDLE, RECONF, GAP, RUN, HIT, MISS, DONE), LFSR tap mask.
//  Sub-module lfsr16 (clk, rst, seed, q[15:0]); the rest is a single FSM plus counters.
// TESTING
//  1) rst=1 for 3 cycles -> all outputs 0, state IDLE; start pulse -> Reconfigure high exactly 1 cycle.
//  2) SEED=16'hACE1, GAP_W=8 -> GAP lasts GAP_MIN+lfsr[7:0]+1 cycles, checked against a model.
//     btn 7 cycles after En rise -> hit_p, score=1, last_rt=7.
//  3) btn during GAP -> miss_p, En never asserted, round_idx 0->1.
//  4) LED_timeout in RUN -> miss_p; same-cycle btn+LED_timeout -> hit_p only.
//  5) ROUNDS=3, sequence hit, miss, hit -> done=1, score=2, round_idx=2; start restarts with score=0.
//  6) abort during RUN -> En=0 next cycle, IDLE. rst during GAP -> IDLE, LFSR=SEED.
//     rt_cnt saturates at 16'hFFFF with RT_W=16.

Source files
------------

// File: rtl/led_round_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module  : led_round_controller_pkg
// Brief   : State encodings and LFSR helpers shared by the round controller.
// Revision: 1.0 - initial release
// ============================================================================
package led_round_controller_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RECONF = 3'd1,
    S_GAP    = 3'd2,
    S_RUN    = 3'd3,
    S_HIT    = 3'd4,
    S_MISS   = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  // Galois form of x^16 + x^14 + x^13 + x^11 + 1 (right-shifting).
  localparam logic [15:0] c_lfsr_taps = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? c_lfsr_taps : 16'h0000);
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_round_controller_lfsr16.sv
`default_nettype none
// ============================================================================
// Module  : lfsr16
// Brief   : Free-running 16-bit Galois LFSR; loads seed on reset.
// Revision: 1.0 - initial release
// ============================================================================
module lfsr16
  import led_round_controller_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] r_lfsr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr <= seed;
    end else begin
      r_lfsr <= lfsr_step(r_lfsr);
    end
  end

  assign q = r_lfsr;

endmodule
`default_nettype wire

// File: rtl/led_round_controller.sv
`default_nettype none
// ============================================================================
// Module  : led_round_controller
// Brief   : Reaction-game sequencer driving LED_Timer reload/enable and scoring.
// Revision: 1.0 - initial release
// ============================================================================
module led_round_controller
  import led_round_controller_pkg::*;
#(
  parameter int          ROUNDS  = 5,
  parameter int          GAP_MIN = 50,
  parameter int          GAP_W   = 8,
  parameter int          RT_W    = 16,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic            btn,
  input  logic            LED_timeout,
  output logic            Reconfigure,
  output logic            En,
  output logic            busy,
  output logic            done,
  output logic            hit_p,
  output logic            miss_p,
  output logic [3:0]      round_idx,
  output logic [3:0]      score,
  output logic [RT_W-1:0] last_rt
);

  localparam int              c_gap_cw   = $clog2(GAP_MIN + (1 << GAP_W));
  localparam logic [15:0]     c_gap_mask = 16'((32'd1 << GAP_W) - 32'd1);
  localparam logic [RT_W-1:0] c_rt_max   = '1;
  localparam logic [3:0]      c_last_idx = 4'(ROUNDS - 1);

  state_t                r_state;
  state_t                w_next;
  logic [15:0]           w_lfsr;
  logic [15:0]           w_gap_add;
  logic [c_gap_cw-1:0]   r_gap_cnt;
  logic [RT_W-1:0]       r_rt_cnt;
  logic [RT_W-1:0]       w_rt_inc;
  logic                  w_last_round;

  logic                  r_reconf;
  logic                  r_en;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_hit;
  logic                  r_miss;
  logic [3:0]            r_round;
  logic [3:0]            r_score;
  logic [RT_W-1:0]       r_last_rt;

  lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .seed (SEED),
    .q    (w_lfsr)
  );

  assign w_gap_add    = w_lfsr & c_gap_mask;
  assign w_rt_inc     = (r_rt_cnt == c_rt_max) ? c_rt_max : r_rt_cnt + 1'b1;
  assign w_last_round = (r_round == c_last_idx);

  always_comb begin
    w_next = r_state;
    if (abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: if (start) w_next = S_RECONF;
        S_RECONF:       w_next = S_GAP;
        S_GAP: begin
          if (btn)                  w_next = S_MISS;
          else if (r_gap_cnt == '0) w_next = S_RUN;
        end
        S_RUN: begin
          // A press in the same cycle as the timeout still counts as a hit.
          if (btn)              w_next = S_HIT;
          else if (LED_timeout) w_next = S_MISS;
        end
        S_HIT, S_MISS:  w_next = w_last_round ? S_DONE : S_RECONF;
        default:        w_next = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_reconf  <= 1'b0;
      r_en      <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_hit     <= 1'b0;
      r_miss    <= 1'b0;
      r_round   <= '0;
      r_score   <= '0;
      r_last_rt <= '0;
      r_gap_cnt <= '0;
      r_rt_cnt  <= '0;
    end else begin
      r_state  <= w_next;
      r_reconf <= (w_next == S_RECONF);
      r_en     <= (w_next == S_RUN);
      r_busy   <= (w_next != S_IDLE) && (w_next != S_DONE);
      r_done   <= (w_next == S_DONE);
      r_hit    <= (w_next == S_HIT);
      r_miss   <= (w_next == S_MISS);
      if (!abort) begin
        case (r_state)
          S_IDLE, S_DONE: begin
            if (start) begin
              r_score <= '0;
              r_round <= '0;
            end
          end
          S_RECONF: r_gap_cnt <= c_gap_cw'(GAP_MIN) + c_gap_cw'(w_gap_add);
          S_GAP: begin
            if (r_gap_cnt != '0) r_gap_cnt <= r_gap_cnt - 1'b1;
            r_rt_cnt <= '0;
          end
          S_RUN: begin
            r_rt_cnt <= w_rt_inc;
            if (btn) begin
              r_last_rt <= w_rt_inc;
              r_score   <= r_score + 1'b1;
            end
          end
          S_HIT, S_MISS: begin
            if (!w_last_round) r_round <= r_round + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign Reconfigure = r_reconf;
  assign En          = r_en;
  assign busy        = r_busy;
  assign done        = r_done;
  assign hit_p       = r_hit;
  assign miss_p      = r_miss;
  assign round_idx   = r_round;
  assign score       = r_score;
  assign last_rt     = r_last_rt;

endmodule
`default_nettype wire

// File: tb/tb_led_round_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_led_round_controller
// Brief   : Directed self-checking bench for led_round_controller (ROUNDS=3).
// Revision: 1.0 - initial release
// ============================================================================
module tb_led_round_controller;

  localparam int          ROUNDS  = 3;
  localparam int          GAP_MIN = 50;
  localparam int          GAP_W   = 8;
  localparam int          RT_W    = 16;
  localparam logic [15:0] SEED    = 16'hACE1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic            btn = 1'b0;
  logic            LED_timeout = 1'b0;
  logic            Reconfigure, En, busy, done, hit_p, miss_p;
  logic [3:0]      round_idx, score;
  logic [RT_W-1:0] last_rt;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_lfsr;

  led_round_controller #(
    .ROUNDS(ROUNDS), .GAP_MIN(GAP_MIN), .GAP_W(GAP_W), .RT_W(RT_W), .SEED(SEED)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .btn         (btn),
    .LED_timeout (LED_timeout),
    .Reconfigure (Reconfigure),
    .En          (En),
    .busy        (busy),
    .done        (done),
    .hit_p       (hit_p),
    .miss_p      (miss_p),
    .round_idx   (round_idx),
    .score       (score),
    .last_rt     (last_rt)
  );

  always #5 clk = ~clk;

  // Reference LFSR: x^16+x^14+x^13+x^11, right-shifting Galois form.
  function automatic logic [15:0] model_step(input logic [15:0] v);
    logic [15:0] n;
    n = v >> 1;
    if (v[0]) n = n ^ 16'b1011_0100_0000_0000;
    return n;
  endfunction

  always @(posedge clk) m_lfsr <= rst ? SEED : model_step(m_lfsr);

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered at the negedge where RECONF is expected; leaves at the first negedge with En high.
  task automatic wait_gap(input string tag, input int exp_len);
    int n;
    check({tag, "_reconf"}, 32'(Reconfigure), 32'd1);
    tick();
    check({tag, "_reconf_1cyc"}, 32'(Reconfigure), 32'd0);
    n = 0;
    while (!En && n < 400) begin
      n++;
      tick();
    end
    check({tag, "_gap_len"}, 32'(n), 32'(exp_len));
  endtask

  task automatic pulse_btn();
    btn = 1'b1;
    tick();
    btn = 1'b0;
  endtask

  logic [29:0] w_all;
  assign w_all = {Reconfigure, En, busy, done, hit_p, miss_p, round_idx, score, last_rt};

  initial begin
    int en_seen;

    // Reset state.
    repeat (3) tick();
    check("reset_outputs", 32'(w_all), 32'd0);
    rst = 1'b0;
    tick();
    check("idle_busy", 32'(busy), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);

    // Game 1, round 0: hit 7 cycles after En rise.
    wait_gap("g1r0", GAP_MIN + int'(m_lfsr[7:0]) + 1);
    repeat (6) tick();
    pulse_btn();
    check("g1r0_hit_p", 32'(hit_p), 32'd1);
    check("g1r0_en_low", 32'(En), 32'd0);
    tick();
    check("g1r0_hit_1cyc", 32'(hit_p), 32'd0);
    check("g1r0_score", 32'(score), 32'd1);
    check("g1r0_last_rt", 32'(last_rt), 32'd7);
    check("g1r0_round", 32'(round_idx), 32'd1);

    // Game 1, round 1: false start during GAP.
    check("g1r1_reconf", 32'(Reconfigure), 32'd1);
    en_seen = 0;
    repeat (5) begin
      tick();
      if (En) en_seen++;
    end
    pulse_btn();
    if (En) en_seen++;
    check("g1r1_miss_p", 32'(miss_p), 32'd1);
    check("g1r1_hit_p", 32'(hit_p), 32'd0);
    check("g1r1_en_never", 32'(en_seen), 32'd0);
    tick();
    check("g1r1_round", 32'(round_idx), 32'd2);
    check("g1r1_score", 32'(score), 32'd1);

    // Game 1, round 2: press and timeout together -> hit wins.
    wait_gap("g1r2", GAP_MIN + int'(m_lfsr[7:0]) + 1);
    repeat (3) tick();
    btn = 1'b1;
    LED_timeout = 1'b1;
    tick();
    btn = 1'b0;
    LED_timeout = 1'b0;
    check("g1r2_hit_p", 32'(hit_p), 32'd1);
    check("g1r2_no_miss", 32'(miss_p), 32'd0);
    tick();
    check("g1_done", 32'(done), 32'd1);
    check("g1_done_busy", 32'(busy), 32'd0);
    check("g1_score", 32'(score), 32'd2);
    check("g1_round", 32'(round_idx), 32'd2);
    check("g1_last_rt", 32'(last_rt), 32'd4);
    pulse_btn();
    check("g1_done_hold", 32'({done, score}), 32'h12);

    // Game 2 restarted from DONE.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("g2_restart_score", 32'(score), 32'd0);
    check("g2_restart_round", 32'(round_idx), 32'd0);
    check("g2_restart_done", 32'(done), 32'd0);

    // Game 2, round 0: timeout miss.
    wait_gap("g2r0", GAP_MIN + int'(m_lfsr[7:0]) + 1);
    repeat (2) tick();
    LED_timeout = 1'b1;
    tick();
    LED_timeout = 1'b0;
    check("g2r0_miss_p", 32'(miss_p), 32'd1);
    check("g2r0_no_hit", 32'(hit_p), 32'd0);
    check("g2r0_en_low", 32'(En), 32'd0);
    tick();
    check("g2r0_round", 32'(round_idx), 32'd1);
    check("g2r0_last_rt_hold", 32'(last_rt), 32'd4);

    // Game 2, round 1: abort during RUN.
    wait_gap("g2r1", GAP_MIN + int'(m_lfsr[7:0]) + 1);
    repeat (3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_en", 32'(En), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_hold", 32'({round_idx, score, last_rt}), 32'h1_0_0004);

    // Reset in GAP, then a fresh round whose gap follows from the seed.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    check("rst_gap_outputs", 32'(w_all), 32'd0);
    rst = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    // step(16'hACE1) = 16'hE270 -> gap = 50 + 8'h70 = 162, GAP lasts 163 cycles.
    wait_gap("post_rst", 163);

    // Reaction counter saturation.
    repeat (65540) tick();
    check("sat_en_high", 32'(En), 32'd1);
    pulse_btn();
    check("sat_hit_p", 32'(hit_p), 32'd1);
    tick();
    check("sat_last_rt", 32'(last_rt), 32'hFFFF);
    check("sat_score", 32'(score), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
